// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU and its sequential execution wrapper.
//   - OP_W / DEF_WIDTH / DEF_ID_W : opcode width and default datapath/tag widths
//   - OP_*                        : ALU opcode encodings
//   - state_e                     : execution-unit FSM states
package alu_pkg;

  localparam int OP_W     = 4;
  localparam int DEF_WIDTH = 64;
  localparam int DEF_ID_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_SLL  = 4'd5;
  localparam logic [OP_W-1:0] OP_SRL  = 4'd6;
  localparam logic [OP_W-1:0] OP_SRA  = 4'd7;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd8;
  localparam logic [OP_W-1:0] OP_SLTU = 4'd9;
  localparam logic [OP_W-1:0] OP_EQ   = 4'd10;
  localparam logic [OP_W-1:0] OP_NOR  = 4'd11;
  // Encodings 12..15 are reserved and produce zero.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu.sv
// alu: purely combinational integer ALU.
//   a_i, b_i : WIDTH-bit operands
//   op_i     : OP_W-bit opcode (see alu_pkg)
//   y_o      : WIDTH-bit result, truncated; comparisons return 0/1
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  output logic [WIDTH-1:0] y_o
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] shamt;
  assign shamt = b_i[SH_W-1:0];

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_SLL:  y_o = a_i << shamt;
      OP_SRL:  y_o = a_i >> shamt;
      OP_SRA:  y_o = $unsigned($signed(a_i) >>> shamt);
      OP_SLT:  y_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: y_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      OP_EQ:   y_o = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
      OP_NOR:  y_o = ~(a_i | b_i);
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked execution wrapper around alu plus an iterative
// shift-add multiplier (unsigned, low WIDTH bits).
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/req_ready           : request handshake
//   req_a, req_b, req_op, req_mul : operands, ALU opcode, multiply select
//   req_id                        : tag echoed on rsp_id
//   rsp_valid/rsp_ready           : response handshake
//   rsp_res, rsp_id               : result and its tag (held until accepted)
// ALU ops respond one cycle after accept; multiplies after WIDTH cycles of
// iteration, i.e. rsp_valid appears WIDTH+1 cycles after accept counting the
// accept cycle as the first.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ID_W  = DEF_ID_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [OP_W-1:0]  req_op,
  input  logic             req_mul,
  input  logic [ID_W-1:0]  req_id,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic [ID_W-1:0]  rsp_id
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_res_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] acc_d;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a_i  (req_a),
    .b_i  (req_b),
    .op_i (req_op),
    .y_o  (alu_y)
  );

  // One shift-add step: add the (already shifted) multiplicand when the
  // current multiplier LSB is set; the sum wraps modulo 2^WIDTH.
  assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Gated by rst so nothing is accepted while reset is asserted.
  assign req_ready = (state_q == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_res_q   <= '0;
      rsp_id_q    <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            rsp_id_q <= req_id;
            if (req_mul) begin
              mcand_q  <= req_a;
              mplier_q <= req_b;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= MUL;
            end else begin
              rsp_res_q   <= alu_y;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end
        end
        MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          // The last step's sum goes straight to the result register.
          if (cnt_q == CNT_LAST) begin
            rsp_res_q   <= acc_d;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  localparam int W  = 64;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  req_a = '0;
  logic [W-1:0]  req_b = '0;
  logic [3:0]    req_op = '0;
  logic          req_mul = 1'b0;
  logic [IW-1:0] req_id = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [W-1:0]  rsp_res;
  logic [IW-1:0] rsp_id;

  alu_exec_unit #(.WIDTH(W), .ID_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .req_mul   (req_mul),
    .req_id    (req_id),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]  res;
    logic [IW-1:0] id;
    int            lat;
    int            acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  bit active = 1'b0;
  logic [W-1:0]  hold_res;
  logic [IW-1:0] hold_id;
  bit stream_mode = 1'b0;
  int prev_first = -1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops an expectation when a new response first appears, then
  // checks it stays stable until the cycle it is accepted.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (!active) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual id=%0d res=%h required=no response", rsp_id, rsp_res);
        end else begin
          mon_e = sb.pop_front();
          $display("RSP id=%0d res=%h lat=%0d", rsp_id, rsp_res, cyc - mon_e.acc + 1);
          chk("rsp_res", rsp_res, mon_e.res);
          chk("rsp_id", W'(rsp_id), W'(mon_e.id));
          chk("rsp_latency", W'(cyc - mon_e.acc + 1), W'(mon_e.lat));
          if (stream_mode && prev_first >= 0)
            chk("stream_interval", W'(cyc - prev_first), W'(2));
          prev_first = cyc;
        end
        active   = 1'b1;
        hold_res = rsp_res;
        hold_id  = rsp_id;
      end else begin
        chk("rsp_res_stable", rsp_res, hold_res);
        chk("rsp_id_stable", W'(rsp_id), W'(hold_id));
      end
      if (rsp_ready) active = 1'b0;
    end
  end

  // Called at a negedge; returns at the negedge right after the accept edge
  // with req_valid still high.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                       input logic mul, input logic [IW-1:0] id,
                       input logic [W-1:0] res, input int lat);
    int n = 0;
    req_a = a; req_b = b; req_op = op; req_mul = mul; req_id = id;
    req_valid = 1'b1;
    #1;
    while (req_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL req_timeout actual req_ready=%b required=1 within 300 cycles", req_ready);
      req_valid = 1'b0;
      return;
    end
    sb.push_back('{res, id, lat, cyc + 1});
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || active) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || active) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual pending=%0d required=0", sb.size());
      sb.delete();
      active = 1'b0;
    end
    @(negedge clk);
  endtask

  logic [W-1:0] st_a  [8] = '{64'd5, 64'd3, 64'hf0, 64'hf0, 64'hff, 64'd1,
                              64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
  logic [W-1:0] st_b  [8] = '{64'd3, 64'd5, 64'h3c, 64'h0f, 64'h0f, 64'd63, 64'd4, 64'd4};
  logic [W-1:0] st_y  [8] = '{64'd8, 64'hffff_ffff_ffff_fffe, 64'h30, 64'hff, 64'hf0,
                              64'h8000_0000_0000_0000, 64'h0800_0000_0000_0000,
                              64'hf800_0000_0000_0000};

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", W'(req_ready), W'(0));
    chk("rst_rsp_valid", W'(rsp_valid), W'(0));
    chk("rst_rsp_res", rsp_res, '0);
    chk("rst_rsp_id", W'(rsp_id), W'(0));
    rst = 1'b0;
    #1;
    chk("idle_req_ready", W'(req_ready), W'(1));
    @(negedge clk);

    // Single-cycle ALU ops
    issue(64'hffff_ffff_ffff_fff0, 64'd0, 4'd8, 1'b0, 4'd3, 64'd1, 1);
    req_valid = 1'b0; drain();
    issue(64'hffff_ffff_ffff_fff0, 64'd0, 4'd15, 1'b0, 4'd4, 64'd0, 1);
    req_valid = 1'b0; drain();
    issue(64'hffff_ffff_ffff_fff0, 64'd0, 4'd9, 1'b0, 4'd5, 64'd0, 1);
    req_valid = 1'b0; drain();
    issue(64'd5, 64'd5, 4'd10, 1'b0, 4'd6, 64'd1, 1);
    req_valid = 1'b0; drain();
    issue(64'd0, 64'd0, 4'd11, 1'b0, 4'd7, 64'hffff_ffff_ffff_ffff, 1);
    req_valid = 1'b0; drain();

    // Multiplies (req_op is don't-care)
    issue(64'd7, 64'd6, 4'd1, 1'b1, 4'd1, 64'd42, 65);
    req_valid = 1'b0; drain();
    issue(64'hffff_ffff_ffff_ffff, 64'd2, 4'd0, 1'b1, 4'd2, 64'hffff_ffff_ffff_fffe, 65);
    req_valid = 1'b0; drain();

    // Backpressure: hold rsp_ready low for 10 cycles, pulse a request
    rsp_ready = 1'b0;
    issue(64'd5, 64'd3, 4'd0, 1'b0, 4'd9, 64'd8, 1);
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_req_ready", W'(req_ready), W'(0));
      if (i == 4) begin
        req_id = 4'd12; req_a = 64'd100; req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("stall_rsp_valid", W'(rsp_valid), W'(1));
    rsp_ready = 1'b1;
    drain();

    // Reset 20 cycles into a multiply
    issue(64'd3, 64'd5, 4'd0, 1'b1, 4'd10, 64'd15, 65);
    req_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    #1;
    chk("mrst_rsp_valid", W'(rsp_valid), W'(0));
    chk("mrst_rsp_res", rsp_res, '0);
    chk("mrst_rsp_id", W'(rsp_id), W'(0));
    chk("mrst_req_ready", W'(req_ready), W'(1));
    repeat (80) @(negedge clk);
    issue(64'd9, 64'd9, 4'd0, 1'b1, 4'd11, 64'd81, 65);
    req_valid = 1'b0; drain();

    // Back-to-back stream, ids 0..7
    stream_mode = 1'b1;
    prev_first  = -1;
    for (int i = 0; i < 8; i++)
      issue(st_a[i], st_b[i], 4'(i), 1'b0, IW'(i), st_y[i], 1);
    req_valid = 1'b0;
    drain();
    stream_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Sequential execution wrapper around the existing combinational `alu`.
- Accepts operand/opcode requests on a valid/ready handshake and returns tagged results on a second valid/ready handshake.
- Adds an iterative shift-add multiply path alongside the single-cycle ALU ops.
- Is the responder that testbenches and the NPC execute stage drive, replacing free-running combinational instantiation.

Parameters:
WIDTH, 64, operand/result width; passed to `alu`
ID_W, 4, request tag width, returned unchanged with the result

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request this cycle
req_a  in  WIDTH  operand A
req_b  in  WIDTH  operand B
req_op  in  4  ALU opcode, passed unchanged to `alu`; ignored when req_mul=1
req_mul  in  1  1 = multiply (low WIDTH bits of A*B, unsigned)
req_id  in  ID_W  request tag
rsp_valid  out  1  result present
rsp_ready  in  1  consumer accepts result
rsp_res  out  WIDTH  result
rsp_id  out  ID_W  tag of the request that produced rsp_res

Behaviour:
- Reset:
  - Sampled on posedge clk only, one clock (`clk`), synchronous active-high reset (`rst`).
  - Forces state=IDLE, rsp_valid=0, rsp_res=0, rsp_id=0, iteration counter=0.
  - req_ready is 0 while rst=1.
  - Reset mid-multiply abandons the operation; no response is ever produced for it.
- Handshakes:
  - A transfer occurs on a posedge with valid=1 and ready=1.
  - req_valid may rise regardless of req_ready.
  - rsp_valid, rsp_res and rsp_id hold stable until accepted.
- FSM states: IDLE, MUL, RESP.
  - IDLE:
    - req_ready=1 only in IDLE.
    - On accept with req_mul=0: capture the `alu` output computed from the request inputs the same cycle into rsp_res; latch req_id; go to RESP. Latency 1 cycle (rsp_valid high the cycle after accept).
    - On accept with req_mul=1: latch multiplicand=A, multiplier=B, acc=0, cnt=0, id; go to MUL.
  - MUL:
    - Each cycle: if multiplier[0], acc += multiplicand (mod 2^WIDTH). Then multiplicand <<= 1, multiplier >>= 1, cnt++.
    - After exactly WIDTH iterations (cnt==WIDTH-1 step), rsp_res=acc and go to RESP.
    - No early termination: latency is exactly WIDTH+1 cycles from accept to rsp_valid.
  - RESP:
    - rsp_valid=1.
    - On rsp_ready: go to IDLE, rsp_valid drops the next cycle.
    - Back-to-back: the accept in IDLE occurs at the earliest the cycle after rsp acceptance. Throughput for ALU ops is 1 per 2 cycles; bubbles are acceptable.
- Arithmetic: all results truncated to WIDTH bits; overflow is silent; multiply is unsigned low half.
- Simultaneous events:
  - rst overrides any handshake in the same cycle.
  - req_valid in non-IDLE states is ignored (req_ready=0), and the request must be held by the sender.
- rsp_ready held 0 indefinitely: the unit stalls in RESP and keeps its outputs constant.

Decomposition:
- Shared package `alu_pkg`: opcode width constant (4), FSM state enum {IDLE, MUL, RESP}, default WIDTH/ID_W constants.
- One sub-module: the existing `alu` (instantiated once, WIDTH passed through).
- The multiply datapath stays inline; no separate module.

Test Plan:
1. ALU op, WIDTH=64: a=64'hfffffffffffffff0, b=0, op=4'd8, id=3. Required: rsp_valid 1 cycle after accept; rsp_res equals a standalone `alu #(64)` with identical inputs; rsp_id=3. Repeat with op=4'd15, id=4.
2. Multiply: a=7, b=6, id=1. Required: rsp_valid exactly 65 cycles after accept, rsp_res=42. Also a=64'hffffffffffffffff, b=2 -> rsp_res=64'hfffffffffffffffe (truncation).
3. Backpressure: after any response, hold rsp_ready=0 for 10 cycles. Required: rsp_valid/rsp_res/rsp_id constant; req_ready=0 throughout; a req_valid pulse during the stall is not accepted.
4. Reset mid-multiply: assert rst for 1 cycle 20 cycles into a multiply. Required: next cycle rsp_valid=0, rsp_res=0, rsp_id=0, req_ready=1; the abandoned multiply never produces a response; a subsequent request completes normally.
5. Back-to-back stream: 8 ALU requests with req_valid and rsp_ready held high, ids 0..7. Required: responses in order with ids 0..7, one every 2 cycles, no lost or duplicated ids.
